// File: rtl/counter_seq_ctrl.sv
// Interval-timer sequencer for an external up counter: owns its enable/clear,
// pulses done each time the programmed period elapses, flags out-of-range counts.
module counter_seq_ctrl #(
  parameter int unsigned CW  = 4,
  parameter int unsigned PDW = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic           mode,
  input  logic [CW-1:0]  period,
  input  logic [CW-1:0]  cnt_value,
  output logic           cnt_enable,
  output logic           cnt_clear,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [PDW-1:0] periods_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic [CW-1:0] period_q;
  logic          mode_q;
  logic [CW-1:0] last_cnt;
  logic          err_d;
  logic          load;
  logic          pd_inc;

  // period_q is never 0 while in RUN, so last_cnt is only used in range
  assign last_cnt = period_q - CW'(1);

  // next-state, error and bookkeeping decode
  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    load    = 1'b0;
    pd_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          if (period != '0) begin
            load    = 1'b1;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_value == last_cnt) begin
          state_d = S_DONE;
        end else if (cnt_value > last_cnt) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        pd_inc  = 1'b1;
        state_d = (mode_q && !stop) ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // counter enable must follow the live count so the counter stops on P-1
  always_comb begin
    cnt_enable = 1'b0;
    if (state == S_RUN && cnt_value != last_cnt) begin
      cnt_enable = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      period_q     <= '0;
      mode_q       <= 1'b0;
      periods_done <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cnt_clear    <= 1'b1;
    end else begin
      state     <= state_d;
      err       <= err_d;
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      cnt_clear <= (state_d != S_RUN);
      if (load) begin
        period_q     <= period;
        mode_q       <= mode;
        periods_done <= '0;
      end else if (pd_inc && periods_done != '1) begin
        periods_done <= periods_done + PDW'(1);
      end
    end
  end

endmodule
